// File: rtl/step_sequencer.sv
// step_sequencer: issues one step pulse per instruction, waits for done or a watchdog timeout, and stops after the programmed count
module step_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             done,
  input  logic [CNT_W-1:0] max_count,
  output logic             step,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] timeout_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  state_t             r_state, w_next;
  logic               r_start_q, r_done_q;
  logic [CNT_W-1:0]   r_max, r_instr, r_tmo;
  logic [TMR_W-1:0]   r_tmr;
  logic               w_start_rise, w_done_rise, w_tmo, w_launch;
  assign w_start_rise  = start & ~r_start_q;
  assign w_done_rise   = done & ~r_done_q;
  assign w_tmo         = r_tmr == TMR_W'(TIMEOUT - 1);
  assign w_launch      = w_start_rise & (r_state == IDLE || r_state == FINISH);
  assign step          = r_state == ISSUE;
  assign busy          = r_state == ISSUE || r_state == WAIT;
  assign finish        = r_state == FINISH;
  assign instr_count   = r_instr;
  assign timeout_count = r_tmo;
  // next state: a new run is routed on the live max_count, the same value latched this edge
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, FINISH: if (w_start_rise) w_next = (max_count == '0) ? FINISH : ISSUE;
      ISSUE:        w_next = WAIT;
      WAIT:         if (w_done_rise || w_tmo) w_next = (r_instr >= r_max) ? FINISH : ISSUE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // edge-detect history for start and done, sampled in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_start_q <= start;
      r_done_q  <= done;
    end
  end
  // run bookkeeping: latched limit, saturating counters and the watchdog timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max   <= '0;
      r_instr <= '0;
      r_tmo   <= '0;
      r_tmr   <= '0;
    end else begin
      if (w_launch) begin
        r_max   <= max_count;
        r_instr <= '0;
        r_tmo   <= '0;
      end
      if (r_state == ISSUE) begin
        r_instr <= r_instr + CNT_W'(~&r_instr);
        r_tmr   <= '0;
      end
      if (r_state == WAIT) begin
        r_tmr <= r_tmr + 1'b1;
        if (!w_done_rise && w_tmo) r_tmo <= r_tmo + CNT_W'(~&r_tmo);
      end
    end
  end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: table-driven runs with a scoreboard of expected step cycles
module tb_step_sequencer;
  localparam int CNT_W = 32;
  localparam int TIMEOUT = 16;
  localparam int PULSE = 0, LOW = 1, HIGH = 2;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, done = 1'b0;
  logic [CNT_W-1:0] max_count = '0;
  logic step, busy, finish;
  logic [CNT_W-1:0] instr_count, timeout_count;
  int n_vec = 0, n_bad = 0, cyc = 0;
  int mode = LOW, dly = 0, since = 1000;
  int exp_q[$];
  typedef struct {
    int mx;
    int md;
    int d;
    bit poke;
    int sp;
    int tmo;
  } vec_t;
  vec_t vt[7];

  step_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TMR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .max_count(max_count),
    .step(step), .busy(busy), .finish(finish),
    .instr_count(instr_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every observed step pulse must match the next expected cycle
  always @(negedge clk) begin
    if (step) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL step_unexpected: got step at cycle %0d expected none", cyc);
      end else chk("step_cycle", cyc, exp_q.pop_front());
    end
  end

  // datapath model: raises done dly cycles after each step, or ties it low/high
  initial forever begin
    @(negedge clk);
    since = step ? 0 : since + 1;
    done = (mode == HIGH) ? 1'b1 : (mode == PULSE && since == dly);
  end

  task automatic run(input vec_t v);
    int c0;
    @(negedge clk);
    mode = v.md;
    dly = v.d;
    max_count = v.mx;
    start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < v.mx; i++) exp_q.push_back(c0 + 1 + i * v.sp);
    @(negedge clk);
    start = 1'b0;
    max_count = 9;
    if (v.poke) begin
      repeat (3) @(negedge clk);
      chk("busy_at_poke", busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < v.mx * v.sp + 5 && !finish; k++) @(negedge clk);
    chk("finish", finish, 1);
    chk("busy_end", busy, 0);
    chk("instr_count", instr_count, v.mx);
    chk("timeout_count", timeout_count, v.tmo);
    chk("steps_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vt[0] = '{mx: 3, md: PULSE, d: 4,  poke: 0, sp: 5,  tmo: 0};
    vt[1] = '{mx: 2, md: LOW,   d: 0,  poke: 0, sp: 17, tmo: 2};
    vt[2] = '{mx: 2, md: PULSE, d: 16, poke: 0, sp: 17, tmo: 0};
    vt[3] = '{mx: 0, md: PULSE, d: 4,  poke: 0, sp: 0,  tmo: 0};
    vt[4] = '{mx: 2, md: HIGH,  d: 0,  poke: 1, sp: 17, tmo: 2};
    vt[5] = '{mx: 4, md: PULSE, d: 2,  poke: 0, sp: 3,  tmo: 0};
    vt[6] = '{mx: 1, md: PULSE, d: 15, poke: 0, sp: 16, tmo: 0};
    #3 rst_n = 1'b0;
    #1;
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_instr", instr_count, 0);
    chk("rst_tmo", timeout_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 7; i++) run(vt[i]);
    @(negedge clk);
    mode = LOW;
    max_count = 5;
    start = 1'b1;
    exp_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_instr", instr_count, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_finish", finish, 0);
    chk("mid_rst_instr", instr_count, 0);
    chk("mid_rst_tmo", timeout_count, 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_finish", finish, 0);
    run(vt[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
    $fatal(1, "timeout");
  end
endmodule
